multi_button_debouncer: RTL and testbench



---
 rtl/multi_button_debouncer_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 101 ++++++++++
 rtl/multi_button_debouncer.sv | 37 +++
 tb/tb_multi_button_debouncer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_button_debouncer_pkg.sv
// multi_button_debouncer_pkg: shared state encoding, counter sizing and default timing.
package multi_button_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DLY,
        HELD,
        RELEASE_DLY
    } btn_state_e;

    localparam int DEF_N_BTN           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_HOLD_CYCLES     = 25000000;
    localparam int DEF_AUTO_REPEAT     = 1;
    localparam int DEF_REPEAT_CYCLES   = 5000000;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchroniser, debounce FSM and hold/repeat counter for one button.
module debounce_channel
    import multi_button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int AUTO_REPEAT     = DEF_AUTO_REPEAT,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pressed_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic hold_pulse_o
);
    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
    localparam bit REPEAT_EN = AUTO_REPEAT != 0;

    logic          meta_q;
    logic          s_q;
    btn_state_e    state_q;
    logic [DW-1:0] deb_q;
    logic [HW-1:0] hold_q;
    logic          ticked_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q          <= 1'b0;
            s_q             <= 1'b0;
            state_q         <= IDLE;
            deb_q           <= '0;
            hold_q          <= '0;
            ticked_q        <= 1'b0;
            pressed_o       <= 1'b0;
            press_pulse_o   <= 1'b0;
            release_pulse_o <= 1'b0;
            hold_pulse_o    <= 1'b0;
        end else begin
            meta_q          <= btn_i;
            s_q             <= meta_q;
            press_pulse_o   <= 1'b0;
            release_pulse_o <= 1'b0;
            hold_pulse_o    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s_q) begin
                        state_q <= PRESS_DLY;
                        deb_q   <= '0;
                    end
                end
                PRESS_DLY: begin
                    if (!s_q) begin
                        state_q <= IDLE;
                    end else if (deb_q == DEB_LAST) begin
                        state_q       <= HELD;
                        pressed_o     <= 1'b1;
                        press_pulse_o <= 1'b1;
                        hold_q        <= '0;
                        ticked_q      <= 1'b0;
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
                HELD: begin
                    // Without auto-repeat the counter freezes once the single tick has fired.
                    if (!s_q) begin
                        state_q <= RELEASE_DLY;
                        deb_q   <= '0;
                    end else if (REPEAT_EN || !ticked_q) begin
                        if (hold_q == (ticked_q ? REP_LAST : HOLD_LAST)) begin
                            hold_pulse_o <= 1'b1;
                            hold_q       <= '0;
                            ticked_q     <= 1'b1;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                end
                RELEASE_DLY: begin
                    if (s_q) begin
                        state_q <= HELD;
                    end else if (deb_q == DEB_LAST) begin
                        state_q         <= IDLE;
                        pressed_o       <= 1'b0;
                        release_pulse_o <= 1'b1;
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/multi_button_debouncer.sv
// multi_button_debouncer: N independent debounced button channels with press/release/hold strobes.
module multi_button_debouncer
    import multi_button_debouncer_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int AUTO_REPEAT     = DEF_AUTO_REPEAT,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] button,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] hold_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .AUTO_REPEAT    (AUTO_REPEAT),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clk            (clk),
            .rst_n          (rst_n),
            .btn_i          (button[i]),
            .pressed_o      (pressed[i]),
            .press_pulse_o  (press_pulse[i]),
            .release_pulse_o(release_pulse[i]),
            .hold_pulse_o   (hold_pulse[i])
        );
    end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// tb_multi_button_debouncer: directed table, corner sequences and random stimulus vs a run-length model.
module tb_multi_button_debouncer;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] button = 2'b00;
    logic [1:0] prs[2], pp[2], rp[2], hp[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_button_debouncer #(.N_BTN(2), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .AUTO_REPEAT(1), .REPEAT_CYCLES(REP)) dut0 (
        .clk(clk), .rst_n(rst_n), .button(button), .pressed(prs[0]),
        .press_pulse(pp[0]), .release_pulse(rp[0]), .hold_pulse(hp[0]));

    multi_button_debouncer #(.N_BTN(2), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .AUTO_REPEAT(0), .REPEAT_CYCLES(REP)) dut1 (
        .clk(clk), .rst_n(rst_n), .button(button), .pressed(prs[1]),
        .press_pulse(pp[1]), .release_pulse(rp[1]), .hold_pulse(hp[1]));

    // Model: level toggles after DEB+1 consecutive synchronised samples opposite to it;
    // hold ticks count samples that are high while the level is high and no release is pending.
    bit         m1[2], m2[2], lvl[2][2];
    int         run[2][2], k[2][2];
    logic [1:0] e_prs[2], e_pp[2], e_rp[2], e_hp[2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m1[c] = 0;
            m2[c] = 0;
            for (int d = 0; d < 2; d++) begin
                lvl[d][c] = 0;
                run[d][c] = 0;
                k[d][c]   = 0;
            end
        end
        for (int d = 0; d < 2; d++) begin
            e_prs[d] = '0; e_pp[d] = '0; e_rp[d] = '0; e_hp[d] = '0;
        end
    endtask

    task automatic model_edge();
        bit s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            e_pp[d] = '0; e_rp[d] = '0; e_hp[d] = '0;
        end
        for (int c = 0; c < 2; c++) begin
            s     = m2[c];
            m2[c] = m1[c];
            m1[c] = button[c];
            for (int d = 0; d < 2; d++) begin
                if (s == lvl[d][c]) begin
                    if (lvl[d][c] && run[d][c] == 0) begin
                        k[d][c]++;
                        e_hp[d][c] = (k[d][c] == HOLD) ||
                            (d == 0 && k[d][c] > HOLD && (k[d][c] - HOLD) % REP == 0);
                    end
                    run[d][c] = 0;
                end else begin
                    run[d][c]++;
                    if (run[d][c] == DEB + 1) begin
                        lvl[d][c]  = !lvl[d][c];
                        run[d][c]  = 0;
                        k[d][c]    = 0;
                        e_pp[d][c] = lvl[d][c];
                        e_rp[d][c] = !lvl[d][c];
                    end
                end
                e_prs[d][c] = lvl[d][c];
            end
        end
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d pressed", d), prs[d], e_prs[d]);
            chk($sformatf("dut%0d press_pulse", d), pp[d], e_pp[d]);
            chk($sformatf("dut%0d release_pulse", d), rp[d], e_rp[d]);
            chk($sformatf("dut%0d hold_pulse", d), hp[d], e_hp[d]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic [1:0] btn;
        logic [1:0] prs;
        logic [1:0] pp;
        logic [1:0] rp;
    } vec_t;
    vec_t tbl[31];

    initial begin
        int dur[2];
        // Clean press/release on ch0, then a simultaneous press/release on both channels.
        for (int i = 0; i < 31; i++) begin
            tbl[i].btn = (i < 8) ? 2'b01 : (i >= 16 && i < 23) ? 2'b11 : 2'b00;
            tbl[i].prs = (i >= 6 && i < 14) ? 2'b01 : (i >= 22 && i < 29) ? 2'b11 : 2'b00;
            tbl[i].pp  = (i == 6) ? 2'b01 : (i == 22) ? 2'b11 : 2'b00;
            tbl[i].rp  = (i == 14) ? 2'b01 : (i == 29) ? 2'b11 : 2'b00;
        end

        model_reset();
        repeat (2) @(negedge clk);
        check_model();
        rst_n = 1'b1;

        for (int i = 0; i < 31; i++) begin
            button = tbl[i].btn;
            step();
            chk($sformatf("tbl%0d pressed", i), prs[0], tbl[i].prs);
            chk($sformatf("tbl%0d press_pulse", i), pp[0], tbl[i].pp);
            chk($sformatf("tbl%0d release_pulse", i), rp[0], tbl[i].rp);
        end

        // Two-cycle glitch inside PRESS_DLY is rejected; the later stable press fires once.
        for (int j = 0; j < 15; j++) begin
            button = (j == 3 || j == 4) ? 2'b00 : 2'b01;
            step();
            chk($sformatf("glitch j%0d press_pulse", j), pp[0], (j == 11) ? 2'b01 : 2'b00);
        end
        button = 2'b00;
        repeat (10) step();

        // Long hold on ch1: repeat ticks on dut0, single tick on dut1.
        button = 2'b10;
        for (int j = 0; j < 7; j++) begin
            step();
            chk($sformatf("hold press j%0d", j), pp[0], (j == 6) ? 2'b10 : 2'b00);
        end
        for (int i = 1; i <= 50; i++) begin
            step();
            chk($sformatf("repeat tick %0d", i), hp[0],
                (i == 20 || i == 28 || i == 36 || i == 44) ? 2'b10 : 2'b00);
            chk($sformatf("single tick %0d", i), hp[1], (i == 20) ? 2'b10 : 2'b00);
        end

        // One-cycle bounce back high inside RELEASE_DLY.
        for (int j = 0; j < 15; j++) begin
            button = (j == 3) ? 2'b10 : 2'b00;
            step();
            chk($sformatf("bounce j%0d release_pulse", j), rp[0], (j == 10) ? 2'b10 : 2'b00);
        end

        // Reset asserted mid-PRESS_DLY with both buttons held through deassertion.
        button = 2'b11;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async reset pressed", prs[0], 2'b00);
        chk("async reset press_pulse", pp[0], 2'b00);
        check_model();
        repeat (2) step();
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            chk($sformatf("post-reset j%0d press_pulse", j), pp[0], (j == 6) ? 2'b11 : 2'b00);
        end

        // Random bursts: short runs exercise bounce rejection, long runs exercise hold/repeat.
        dur[0] = 1;
        dur[1] = 1;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) begin
                dur[c]--;
                if (dur[c] == 0) begin
                    button[c] = ~button[c];
                    dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                         : int'($urandom_range(1, 8));
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
